// File: rtl/vote_arbiter_if.sv
// Button/tally bus between the candidate front-end and vote_arbiter.
// VOTE_TOTAL_EN adds the total_votes running count.
interface vote_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             mode;
    logic             clear_counts;
    logic             candidate1_button_press;
    logic             candidate2_button_press;
    logic             candidate3_button_press;
    logic             candidate4_button_press;
    logic             valid_vote_casted;
    logic [CNT_W-1:0] candidate1_vote;
    logic [CNT_W-1:0] candidate2_vote;
    logic [CNT_W-1:0] candidate3_vote;
    logic [CNT_W-1:0] candidate4_vote;
    logic             busy;
    logic             rejected;
`ifdef VOTE_TOTAL_EN
    logic [CNT_W+1:0] total_votes;
`endif

    modport slave (
        input  mode, clear_counts,
        input  candidate1_button_press, candidate2_button_press,
        input  candidate3_button_press, candidate4_button_press,
        output valid_vote_casted, busy, rejected,
`ifdef VOTE_TOTAL_EN
        output total_votes,
`endif
        output candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote
    );

    modport master (
        output mode, clear_counts,
        output candidate1_button_press, candidate2_button_press,
        output candidate3_button_press, candidate4_button_press,
        input  valid_vote_casted, busy, rejected,
`ifdef VOTE_TOTAL_EN
        input  total_votes,
`endif
        input  candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote
    );
endinterface

// File: rtl/vote_arbiter.sv
// Vote-registration controller: one vote per press/release, ambiguous-press
// rejection, post-vote lockout and saturating tallies. VOTE_TOTAL_EN adds total_votes.
module vote_arbiter #(
    parameter int LOCKOUT_CYCLES = 100000000,
    parameter int CNT_W          = 8
) (
    input logic           clock,
    input logic           reset,
    vote_arbiter_if.slave bus
);
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GRANT, LOCKOUT, RELEASE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic [CNT_W-1:0]  tally_q [4];
    logic [CNT_W-1:0]  tally_d [4];
    logic              valid_q, valid_d;
    logic              rej_q, rej_d;
    logic              busy_q, busy_d;
    logic [3:0]        btn;
    logic              multi, one_hot;
    logic [1:0]        btn_idx;
    logic              clear_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef VOTE_TOTAL_EN
    logic [CNT_W+1:0] total_q, total_d;

    function automatic logic [CNT_W+1:0] sat_inc_total(input logic [CNT_W+1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign bus.total_votes = total_q;
`endif

    assign btn = {bus.candidate4_button_press, bus.candidate3_button_press,
                  bus.candidate2_button_press, bus.candidate1_button_press};
    // Clearing the lowest set bit leaves something only when two or more are high.
    assign multi    = (btn & (btn - 4'd1)) != 4'd0;
    assign one_hot  = (btn != 4'd0) && !multi;
    assign clear_ok = (state_q == IDLE) && bus.mode && bus.clear_counts;

    always_comb begin
        btn_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (btn[i]) btn_idx = 2'(i);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            lock_q  <= '0;
            valid_q <= 1'b0;
            rej_q   <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < 4; i++) tally_q[i] <= '0;
`ifdef VOTE_TOTAL_EN
            total_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lock_q  <= lock_d;
            valid_q <= valid_d;
            rej_q   <= rej_d;
            busy_q  <= busy_d;
            for (int i = 0; i < 4; i++) tally_q[i] <= tally_d[i];
`ifdef VOTE_TOTAL_EN
            total_q <= total_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (!bus.mode) begin
                    if (one_hot) begin
                        idx_d   = btn_idx;
                        state_d = GRANT;
                    end else if (multi) begin
                        state_d = RELEASE;
                    end
                end
            end
            GRANT: begin
                lock_d  = LOCK_LOAD;
                state_d = LOCKOUT;
            end
            LOCKOUT: begin
                if (lock_q == '0) state_d = RELEASE;
                else              lock_d  = lock_q - 1'b1;
            end
            RELEASE: begin
                if (btn == 4'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so each _d here becomes visible one edge later.
    always_comb begin
        for (int i = 0; i < 4; i++) tally_d[i] = tally_q[i];
        valid_d = 1'b0;
        rej_d   = (state_q == IDLE) && !bus.mode && multi;
        busy_d  = (state_d != IDLE);
`ifdef VOTE_TOTAL_EN
        total_d = total_q;
`endif
        if (state_q == GRANT) begin
            tally_d[idx_q] = sat_inc(tally_q[idx_q]);
            valid_d        = 1'b1;
`ifdef VOTE_TOTAL_EN
            total_d        = sat_inc_total(total_q);
`endif
        end else if (clear_ok) begin
            for (int i = 0; i < 4; i++) tally_d[i] = '0;
`ifdef VOTE_TOTAL_EN
            total_d = '0;
`endif
        end
    end

    assign bus.valid_vote_casted = valid_q;
    assign bus.rejected          = rej_q;
    assign bus.busy              = busy_q;
    assign bus.candidate1_vote   = tally_q[0];
    assign bus.candidate2_vote   = tally_q[1];
    assign bus.candidate3_vote   = tally_q[2];
    assign bus.candidate4_vote   = tally_q[3];
endmodule

// File: tb/tb_vote_arbiter.sv
// Bench for vote_arbiter: vector table plus hand sequences, with a scoreboard of
// expected vote/reject pulses checked by a negedge monitor against a tally model.
module tb_vote_arbiter;
    localparam int LOCK  = 4;
    localparam int CNT_W = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    vote_arbiter_if #(.CNT_W(CNT_W)) bus ();

    vote_arbiter #(.LOCKOUT_CYCLES(LOCK), .CNT_W(CNT_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // kind: 0 = vote, 1 = reject, 2 = no response expected
    typedef struct {
        int kind;
        int idx;
        int lat;
        int t0;
    } ev_t;

    typedef struct {
        logic       mode;
        logic [3:0] btn;
        int         hold;
        int         kind;
        int         idx;
    } vec_t;

    ev_t  sb[$];
    vec_t vt[10];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   exp_tally[4];
    int   exp_total;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got unexpected event, expected none", name);
    endtask

    function automatic int dut_tally(input int i);
        case (i)
            0:       return int'(bus.candidate1_vote);
            1:       return int'(bus.candidate2_vote);
            2:       return int'(bus.candidate3_vote);
            default: return int'(bus.candidate4_vote);
        endcase
    endfunction

    task automatic chk_tallies(input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_tally%0d", tag, i + 1), dut_tally(i), exp_tally[i]);
`ifdef VOTE_TOTAL_EN
        chk($sformatf("%s_total", tag), int'(bus.total_votes), exp_total);
`endif
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) exp_tally[i] = 0;
        exp_total = 0;
    endtask

    always @(negedge clock) begin : monitor
        ev_t e;
        if (reset) begin
            if (bus.valid_vote_casted) begin
                n_valid++;
                if (sb.size() == 0) fail_now("unexpected_vote");
                else begin
                    e = sb.pop_front();
                    chk("vote_kind", e.kind, 0);
                    chk("vote_latency", cyc - e.t0, e.lat);
                    if (exp_tally[e.idx] < 255) exp_tally[e.idx]++;
                    if (exp_total < 1023) exp_total++;
                    chk_tallies("vote");
                end
            end
            if (bus.rejected) begin
                if (sb.size() == 0) fail_now("unexpected_reject");
                else begin
                    e = sb.pop_front();
                    chk("reject_kind", e.kind, 1);
                    chk("reject_latency", cyc - e.t0, e.lat);
                    chk_tallies("reject");
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_btn(input logic [3:0] b);
        bus.candidate1_button_press = b[0];
        bus.candidate2_button_press = b[1];
        bus.candidate3_button_press = b[2];
        bus.candidate4_button_press = b[3];
    endtask

    task automatic press(input logic [3:0] b, input int hold, input int kind, input int idx);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.lat  = (kind == 0) ? 2 : 1;
        e.t0   = cyc;
        if (kind != 2) sb.push_back(e);
        drive_btn(b);
        repeat (hold) tick();
        drive_btn(4'b0000);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clock);
        while (bus.busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (bus.busy) chk($sformatf("%s_idle_timeout", tag), 1, 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int v0;
        int t0;
        bus.mode         = 1'b0;
        bus.clear_counts = 1'b0;
        drive_btn(4'b0000);
        model_clear();

        vt[0] = '{1'b0, 4'b0001,  1, 0, 0};
        vt[1] = '{1'b0, 4'b0100, 20, 0, 2};
        vt[2] = '{1'b0, 4'b1001,  1, 1, 0};
        vt[3] = '{1'b0, 4'b1001, 10, 1, 0};
        vt[4] = '{1'b1, 4'b0010,  3, 2, 0};
        vt[5] = '{1'b0, 4'b1000,  2, 0, 3};
        vt[6] = '{1'b0, 4'b0110,  1, 1, 0};
        vt[7] = '{1'b0, 4'b1110,  1, 1, 0};
        vt[8] = '{1'b1, 4'b1111,  2, 2, 0};
        vt[9] = '{1'b0, 4'b0010,  1, 0, 1};

        repeat (3) tick();
        chk_tallies("reset");
        chk("reset_valid", int'(bus.valid_vote_casted), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_rejected", int'(bus.rejected), 0);
        reset = 1'b1;
        tick();

        // Single one-cycle press: one vote, busy for GRANT + lockout + release.
        v0 = n_valid;
        press(4'b0010, 1, 0, 1);
        busy_cnt = 0;
        repeat (11) begin
            @(negedge clock);
            if (bus.busy) busy_cnt++;
        end
        chk("t1_busy_cycles", busy_cnt, 6);
        wait_idle("t1");
        chk("t1_valid_pulses", n_valid - v0, 1);
        chk("t1_sb_drain", sb.size(), 0);
        chk_tallies("t1");

        for (int i = 0; i < 10; i++) begin
            bus.mode = vt[i].mode;
            tick();
            press(vt[i].btn, vt[i].hold, vt[i].kind, vt[i].idx);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_sb_drain", i), sb.size(), 0);
            chk_tallies($sformatf("vec%0d", i));
        end

        // Held button: stays in RELEASE until let go, then IDLE one edge later.
        bus.mode = 1'b0;
        tick();
        press(4'b0100, 20, 0, 2);
        chk("t2_busy_while_held", int'(bus.busy), 1);
        @(negedge clock);
        chk("t2_busy_before_edge", int'(bus.busy), 1);
        @(negedge clock);
        chk("t2_idle_after_release", int'(bus.busy), 0);
        tick();
        chk("t2_sb_drain", sb.size(), 0);
        chk_tallies("t2");

        // 260 votes for candidate 1: tally saturates, every vote still pulses.
        v0 = n_valid;
        t0 = exp_total;
        for (int i = 0; i < 260; i++) begin
            press(4'b0001, 1, 0, 0);
            wait_idle("t4");
        end
        chk("t4_valid_pulses", n_valid - v0, 260);
        chk("t4_c1_saturated", dut_tally(0), 255);
        chk("t4_sb_drain", sb.size(), 0);
        chk_tallies("t4");
`ifdef VOTE_TOTAL_EN
        chk("t4_total_delta", int'(bus.total_votes) - t0, 260);
`endif

        // Display mode: buttons ignored, clear honoured in IDLE.
        bus.mode = 1'b1;
        tick();
        press(4'b0010, 2, 2, 0);
        tick();
        chk_tallies("t5_mode1_press");
        bus.clear_counts = 1'b1;
        tick();
        bus.clear_counts = 1'b0;
        model_clear();
        @(negedge clock);
        chk_tallies("t5_clear");
        tick();

        bus.mode = 1'b0;
        tick();
        press(4'b0010, 1, 0, 1);
        wait_idle("t5_vote");
        bus.clear_counts = 1'b1;
        tick();
        bus.clear_counts = 1'b0;
        @(negedge clock);
        chk_tallies("t5_clear_mode0_ignored");
        tick();

        // Mode flips to display during lockout: vote completes, clear is not honoured.
        press(4'b0100, 1, 0, 2);
        bus.mode = 1'b1;
        bus.clear_counts = 1'b1;
        tick();
        tick();
        bus.clear_counts = 1'b0;
        wait_idle("t5_lockout");
        bus.mode = 1'b0;
        tick();
        chk("t5_lockout_sb_drain", sb.size(), 0);
        chk_tallies("t5_clear_busy_ignored");

        // Asynchronous reset in the middle of lockout.
        press(4'b1000, 1, 0, 3);
        tick();
        tick();
        chk("t6_in_lockout", int'(bus.busy), 1);
        chk("t6_c4_voted", dut_tally(3), exp_tally[3]);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk_tallies("t6_async_reset");
        chk("t6_reset_busy", int'(bus.busy), 0);
        chk("t6_reset_valid", int'(bus.valid_vote_casted), 0);
        chk("t6_reset_rejected", int'(bus.rejected), 0);
        chk("t6_sb_drain", sb.size(), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        press(4'b0001, 1, 0, 0);
        wait_idle("t6_after");
        chk("t6_after_sb_drain", sb.size(), 0);
        chk_tallies("t6_after_reset");
        chk("t6_c1_fresh", dut_tally(0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
